// File: rtl/hex_disp_sched.sv
// Time-shared HEX display controller: one external 5-bit segment decoder serves both
// switch fields over a 4-cycle refresh loop; bad/banana values get animated glyphs.
module hex_disp_sched #(
  parameter int unsigned TICK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] SW,
  output logic [4:0] dec_bin,
  input  logic [6:0] dec_seg,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic       upd_done
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_CYCLES - 1);

  localparam logic [6:0] GlyphB     = 7'b0000011;
  localparam logic [6:0] GlyphA     = 7'b0001000;
  localparam logic [6:0] GlyphN     = 7'b0101011;
  localparam logic [6:0] GlyphD     = 7'b0100001;
  localparam logic [6:0] GlyphBlank = 7'b1111111;

  typedef enum logic [1:0] {StCap, StDecLo, StDecHi, StUpd} state_e;
  typedef enum logic [1:0] {ModeNormal, ModeBad, ModeBanana} mode_e;

  function automatic logic field_bad(input logic [4:0] f);
    return f[4] & (f[3] | f[2]);
  endfunction

  // Glyph of the scrolling "bAnAnA" banner at display position pos for a given offset.
  function automatic logic [6:0] banana_glyph(input logic [2:0] pos, input logic [2:0] off);
    logic [3:0] idx;
    idx = {1'b0, pos} + {1'b0, off};
    if (idx >= 4'd6) idx = idx - 4'd6;
    if (idx == 4'd0) return GlyphB;
    else if (idx[0]) return GlyphA;
    else return GlyphN;
  endfunction

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d, cls;
  logic [9:0]      sw_q, sw_d;
  logic [6:0]      seg_lo_q, seg_lo_d, seg_hi_q, seg_hi_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d, phase_q, phase_d, wrap;
  logic [2:0]      off_q, off_d;
  logic [5:0][6:0] hex_q, hex_d;

  assign wrap = (cnt_q == CntMax);

  always_comb begin
    if (sw_q[4:0] == 5'd7 && sw_q[9:5] == 5'd10) cls = ModeBanana;
    else if (field_bad(sw_q[4:0]) || field_bad(sw_q[9:5])) cls = ModeBad;
    else cls = ModeNormal;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    sw_d     = sw_q;
    seg_lo_d = seg_lo_q;
    seg_hi_d = seg_hi_q;
    cnt_d    = wrap ? '0 : cnt_q + CntW'(1);
    tick_d   = tick_q | wrap;
    phase_d  = phase_q;
    off_d    = off_q;
    hex_d    = hex_q;
    dec_bin  = '0;
    upd_done = 1'b0;
    unique case (state_q)
      StCap: begin
        sw_d    = SW;
        state_d = StDecLo;
      end
      StDecLo: begin
        dec_bin  = sw_q[4:0];
        seg_lo_d = dec_seg;
        state_d  = StDecHi;
      end
      StDecHi: begin
        dec_bin  = sw_q[9:5];
        seg_hi_d = dec_seg;
        state_d  = StUpd;
      end
      StUpd: begin
        upd_done = 1'b1;
        state_d  = StCap;
        // Pending tick is consumed here; a wrap in this same cycle is kept for next time.
        tick_d   = wrap;
        if (cls != mode_q) begin
          mode_d  = cls;
          cnt_d   = '0;
          tick_d  = 1'b0;
          phase_d = 1'b0;
          off_d   = '0;
        end else if (tick_q) begin
          if (mode_q == ModeBad) phase_d = ~phase_q;
          if (mode_q == ModeBanana) off_d = (off_q == 3'd5) ? 3'd0 : off_q + 3'd1;
        end
        hex_d = {6{GlyphBlank}};
        unique case (mode_d)
          ModeBad: begin
            if (!phase_d) begin
              hex_d[5] = GlyphB;
              hex_d[4] = GlyphA;
              hex_d[3] = GlyphD;
            end
            hex_d[1] = seg_hi_q;
            hex_d[0] = seg_lo_q;
          end
          ModeBanana: begin
            for (int i = 0; i < 6; i++) hex_d[5-i] = banana_glyph(3'(i), off_d);
          end
          default: begin
            hex_d[1] = seg_hi_q;
            hex_d[0] = seg_lo_q;
          end
        endcase
      end
      default: state_d = StCap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StCap;
      mode_q   <= ModeNormal;
      sw_q     <= '0;
      seg_lo_q <= GlyphBlank;
      seg_hi_q <= GlyphBlank;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      phase_q  <= 1'b0;
      off_q    <= '0;
      hex_q    <= {6{GlyphBlank}};
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      sw_q     <= sw_d;
      seg_lo_q <= seg_lo_d;
      seg_hi_q <= seg_hi_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      phase_q  <= phase_d;
      off_q    <= off_d;
      hex_q    <= hex_d;
    end
  end

  assign HEX5 = hex_q[5];
  assign HEX4 = hex_q[4];
  assign HEX3 = hex_q[3];
  assign HEX2 = hex_q[2];
  assign HEX1 = hex_q[1];
  assign HEX0 = hex_q[0];

endmodule
